// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection traffic-light controller and its front end.
// Holds the walk state encoding, lamp bit indices, the press counter width and a
// saturating-increment helper for that counter.
package traffic_pkg;

  // Walk state encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] SERVING = 2'd2;

  // Lamp bit indices within a {R, Y, G} lamp vector
  localparam int unsigned R = 2;
  localparam int unsigned Y = 1;
  localparam int unsigned G = 0;

  localparam int unsigned PRESS_COUNT_W = 8;

  typedef enum logic [1:0] {
    StIdle    = IDLE,
    StPending = PENDING,
    StServing = SERVING
  } walk_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PRESS_COUNT_W-1:0] sat_inc(input logic [PRESS_COUNT_W-1:0] v);
    return (&v) ? v : v + PRESS_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Synchronizer plus debounce filter for one asynchronous input.
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   raw_i    : asynchronous raw input
//   stable_o : debounced level (registered)
//   rise_o   : one-cycle pulse in the cycle stable_o first reads 1
//   fall_o   : one-cycle pulse in the cycle stable_o first reads 0
// stable_o changes only after DEBOUNCE_CYCLES consecutive synchronized samples
// disagree with it.
module input_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic                   stable_q, stable_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sample != stable_q) begin
      if (cnt_q == CntMax) begin
        // This is the DEBOUNCE_CYCLES-th disagreeing sample in a row.
        stable_d = sample;
        rise_d   = sample;
        fall_d   = ~sample;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/walk_request_frontend.sv
// Input-conditioning front end for the traffic-light controller.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   button_raw   : raw pedestrian push-button
//   sensor_raw   : raw vehicle loop sensor
//   light_walk   : walk lamp from the controller, acknowledges a request (synchronous)
//   button_walk  : latched walk request to the controller
//   sensor       : debounced, stretched vehicle presence
//   walk_pending : request outstanding or re-armed ("wait" lamp)
//   press_count  : saturating count of accepted presses
// All outputs come straight from flops.
module walk_request_frontend
  import traffic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned SENSOR_HOLD     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     button_raw,
  input  logic                     sensor_raw,
  input  logic                     light_walk,
  output logic                     button_walk,
  output logic                     sensor,
  output logic                     walk_pending,
  output logic [PRESS_COUNT_W-1:0] press_count
);

  localparam int unsigned HoldW = (SENSOR_HOLD > 0) ? $clog2(SENSOR_HOLD + 1) : 1;

  logic btn_rise, btn_fall, btn_stable;
  logic sens_rise, sens_fall, sens_stable;
  logic unused_btn;

  input_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button_db (
    .clk_i   (clk),
    .rst_ni  (reset),
    .raw_i   (button_raw),
    .stable_o(btn_stable),
    .rise_o  (btn_rise),
    .fall_o  (btn_fall)
  );

  input_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sensor_db (
    .clk_i   (clk),
    .rst_ni  (reset),
    .raw_i   (sensor_raw),
    .stable_o(sens_stable),
    .rise_o  (sens_rise),
    .fall_o  (sens_fall)
  );

  // Only the button's rising edge matters to the walk logic.
  assign unused_btn = btn_fall ^ btn_stable;

  // ---------------------------------------------------------------------------
  // Walk request state machine
  // ---------------------------------------------------------------------------
  walk_state_e              state_q;
  logic                     rearm_q;
  logic                     button_walk_q;
  logic                     walk_pending_q;
  logic [PRESS_COUNT_W-1:0] press_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      rearm_q        <= 1'b0;
      button_walk_q  <= 1'b0;
      walk_pending_q <= 1'b0;
      press_count_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // light_walk is ignored here; an ack arriving with the press is
          // honoured one cycle later from PENDING.
          if (btn_rise) begin
            state_q        <= StPending;
            button_walk_q  <= 1'b1;
            walk_pending_q <= 1'b1;
            press_count_q  <= sat_inc(press_count_q);
          end
        end
        StPending: begin
          // Presses while already pending are absorbed.
          if (light_walk) begin
            state_q       <= StServing;
            button_walk_q <= 1'b0;
          end
        end
        StServing: begin
          if (btn_rise) begin
            press_count_q <= sat_inc(press_count_q);
          end
          if (!light_walk) begin
            // A press in this very cycle re-arms just like an earlier one.
            if (rearm_q || btn_rise) begin
              state_q        <= StPending;
              button_walk_q  <= 1'b1;
              walk_pending_q <= 1'b1;
            end else begin
              state_q        <= StIdle;
              walk_pending_q <= 1'b0;
            end
            rearm_q <= 1'b0;
          end else if (btn_rise) begin
            rearm_q <= 1'b1;
          end
        end
        default: begin
          state_q        <= StIdle;
          rearm_q        <= 1'b0;
          button_walk_q  <= 1'b0;
          walk_pending_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sensor stretch
  // ---------------------------------------------------------------------------
  logic [HoldW-1:0] hold_q, hold_d;
  logic             sensor_q, sensor_d;

  always_comb begin
    hold_d = hold_q;
    if (sens_fall) begin
      hold_d = HoldW'(SENSOR_HOLD);
    end else if (sens_rise) begin
      hold_d = '0;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HoldW'(1);
    end
    sensor_d = sens_stable | (hold_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q   <= '0;
      sensor_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      sensor_q <= sensor_d;
    end
  end

  assign button_walk  = button_walk_q;
  assign walk_pending = walk_pending_q;
  assign press_count  = press_count_q;
  assign sensor       = sensor_q;

endmodule

// File: doc/walk_request_frontend.md
# walk_request_frontend

Input-conditioning front end for the intersection traffic-light controller. It sits between the raw pedestrian push-button and vehicle loop sensor pins and the controller's `button_walk` and `sensor` inputs. It synchronizes and debounces both raw inputs, latches a pedestrian request until the controller acknowledges it by asserting `light_walk`, and stretches the vehicle sensor so that short loop dropouts are not lost.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages in each input synchronizer; legal range 2–4.
- `DEBOUNCE_CYCLES`, default 8: consecutive identical synchronized samples required before the debounced value changes; must be at least 2.
- `SENSOR_HOLD`, default 4: cycles `sensor` stays high after the debounced sensor falls; 0 disables stretching.

Ports:
- `clk`, input, 1 bit: single system clock; all state updates on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `button_raw`, input, 1 bit: asynchronous pedestrian push-button, high while pressed.
- `sensor_raw`, input, 1 bit: asynchronous vehicle loop sensor, high while a vehicle is present.
- `light_walk`, input, 1 bit: walk lamp from the controller; this is the request acknowledge.
- `button_walk`, output, 1 bit: latched walk request to the controller.
- `sensor`, output, 1 bit: debounced, stretched vehicle presence to the controller.
- `walk_pending`, output, 1 bit: high while a request is outstanding or re-armed; drives the "wait" lamp.
- `press_count`, output, 8 bits: saturating count of accepted presses, for diagnostics.

## Operation
- **Synchronizer.** Each raw input passes through `SYNC_STAGES` flops, all reset to 0.
- **Debounce**, per input:
  - Holds `stable` (reset 0) and a counter (reset 0).
  - When the synchronized sample differs from `stable`, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`−1 and the sample still differs, `stable` toggles and the counter clears.
  - Any sample equal to `stable` clears the counter.
  - The block also produces a one-cycle `rise` pulse when `stable` goes 0→1.
- **Walk state machine** (states IDLE, PENDING, SERVING; reset state IDLE):
  - IDLE: on button `rise`, go to PENDING and increment `press_count`.
  - PENDING: `button_walk`=1. When `light_walk`=1, go to SERVING.
  - SERVING: `button_walk`=0. When `light_walk`=0, go to PENDING if `rearm`=1 (and clear `rearm`), otherwise go to IDLE.
  - Button `rise` in PENDING is absorbed: no count, no state change.
  - Button `rise` in SERVING sets `rearm` and increments `press_count`.
  - `light_walk`=1 while in IDLE: ignored.
  - If `rise` and `light_walk`=1 occur in the same IDLE cycle, go to PENDING. SERVING is entered on the next cycle if `light_walk` is still high.
- **`walk_pending`** = (state≠IDLE) OR `rearm`.
- **`press_count`**: increments by 1 per accepted press and saturates at 255 with no wrap.
- **Sensor stretch**:
  - `sensor` = debounced sensor OR (hold counter ≠ 0).
  - The hold counter loads `SENSOR_HOLD` on the debounced falling edge and decrements to 0.
  - A new debounced rise while the counter is nonzero keeps `sensor` high and clears the counter.
- **Reset values.** `button_walk`=0, `sensor`=0, `walk_pending`=0, `press_count`=0, `rearm`=0, state IDLE.
- **Reset mid-operation** drops a pending request immediately, asynchronously.

## Timing
- Raw edge to debounced change: `SYNC_STAGES`+`DEBOUNCE_CYCLES` rising edges. With defaults this is 10.
- `button_raw` rise to `button_walk`=1: `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1 edges. With defaults this is 11.
- `light_walk` rise to `button_walk`=0: 1 edge. `light_walk` is synchronous to `clk` and is not synchronized.
- `sensor_raw` rise to `sensor`=1: `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1 edges.
- `sensor` falls `SENSOR_HOLD`+1 edges after the debounced fall.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles never reach the outputs.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package `traffic_pkg`:
  - Walk state encoding constants: IDLE=2'd0, PENDING=2'd1, SERVING=2'd2.
  - Lamp index constants: R=2, Y=1, G=0.
  - `PRESS_COUNT_W`=8.
- One sub-module, `input_debounce`: synchronizer plus debounce counter plus `rise`/`fall` pulses, parameterized by `SYNC_STAGES` and `DEBOUNCE_CYCLES`. It is instantiated twice, once for the button and once for the sensor.
- The top level holds the walk state machine, the `rearm` flag, the press counter and the sensor hold counter.

## Test plan
All scenarios use the default parameters.
- **Bounce rejection.** `button_raw` toggles every 3 cycles for 30 cycles, then holds 0 → `button_walk` stays 0 and `press_count` stays 0.
- **Clean press and acknowledge.** `button_raw`=1 for 20 cycles → `button_walk`=1 exactly 11 edges after the rise. Assert `light_walk`=1 → `button_walk`=0 one edge later. Deassert `light_walk` → state IDLE, `walk_pending`=0, `press_count`=1.
- **Re-arm.** A second clean press while `light_walk`=1 → `walk_pending` stays 1 and `press_count`=2. On `light_walk` fall, `button_walk`=1 again the next edge.
- **Sensor stretch.** `sensor_raw` high 15 cycles, low 3 cycles, high 15 cycles → `sensor` stays high continuously. After the final fall, `sensor` drops 10+4+1 edges after the raw fall.
- **Saturation.** 260 clean presses, each acknowledged → `press_count`=255 with no wrap.
- **Async reset.** Pull `reset` low mid-PENDING, between clock edges → `button_walk`, `walk_pending` and `press_count` go to 0 immediately. After release, the state machine is in IDLE.
